sb_tx_serializer: RTL
=====================

# sb_tx_serializer

Sideband transmit back end. Buffers 64-bit framed packets/patterns produced by the sideband TX wrapper (its `o_tx_data_out` / `o_write_enable` pair) in a small FIFO and shifts each word out LSB-first on a single sideband data lane with a forwarded-clock enable. Between packets it enforces the idle gap the sideband link requires. It drives the `i_fifo_full` back-pressure consumed upstream.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in 64-bit words; power of two, ≥ 2.
- `GAP_UI`, 32: idle cycles inserted between packets (gap feature only); ≥ 1.

Ports:
- `i_clk` in 1: serial clock. One clock; reset is asynchronous and active-high (`i_rst`).
- `i_rst` in 1: async active-high reset.
- `i_write_enable` in 1: push `i_tx_data` this cycle.
- `i_tx_data` in 64: packet/pattern word.
- `o_fifo_full` out 1: FIFO count == `DEPTH`.
- `o_fifo_empty` out 1: FIFO count == 0.
- `o_overflow` out 1: one-cycle pulse when a push is dropped.
- `o_ser_data` out 1: serial data bit, registered.
- `o_ser_clk_en` out 1: high exactly during valid data UIs, registered.
- `o_ser_done` out 1: one-cycle pulse coincident with bit 63 of each word.
- `o_busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- FIFO: circular, write/read pointers `$clog2(DEPTH)` bits, wrap naturally; count `$clog2(DEPTH+1)` bits.
- Push accepted iff `i_write_enable` && (count < `DEPTH` || pop in same cycle). Otherwise the word is dropped, FIFO is unchanged, and `o_overflow` pulses the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. Valid when full or when empty with a pop impossible (empty → no pop).
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if FIFO is non-empty, pop the head into the 64-bit shift register, set bit counter = 0, go to SHIFT.
  - SHIFT: present `shreg[0]`, shift right each cycle, bit counter +1. On counter == 63 pulse `o_ser_done`. Next: GAP (gap enabled); otherwise pop and reload if non-empty (stay SHIFT), else IDLE.
  - GAP: `o_ser_data` = 0, `o_ser_clk_en` = 0, gap counter counts to `GAP_UI`-1. On the last gap cycle, pop/reload into SHIFT if non-empty, else IDLE.
- Outside SHIFT, `o_ser_data` = 0 and `o_ser_clk_en` = 0.
- The serializer never pops an empty FIFO. No word is ever partially sent except on reset.

## Timing
- Reset (async, takes effect immediately): all outputs 0 except `o_fifo_empty` = 1; pointers, count and counters = 0; state = IDLE. Reset mid-word aborts the word, and FIFO contents are discarded.
- Push sampled at edge E0: `o_fifo_empty` falls after E0. If IDLE, pop at E1; `o_ser_clk_en` = 1 and `o_ser_data` = bit0 after E1; bit63 after E64 with `o_ser_done`.
- Write-to-first-bit latency: 2 cycles from idle.
- `o_fifo_full` reflects count after each edge. Upstream must drop `i_write_enable` the cycle after it sees full, and overflow is reported when it does not.
- Gap enabled: bit63 of word N is followed by exactly `GAP_UI` dead cycles, then bit0 of word N+1.
- Gap disabled: word N+1 bit0 directly follows word N bit63, with no dead cycle.

## Configuration
- `SB_TX_MIN_GAP_EN` defined: GAP state and gap counter are compiled in, and the inter-packet gap of `GAP_UI` cycles is enforced.
- Not defined: GAP state, counter and `GAP_UI` usage are removed. Packets stream back-to-back with `o_ser_clk_en` held high continuously while the FIFO supplies words.

## Test plan
- Reset, push 64'h0000_0000_0000_0001 → `o_ser_clk_en` high 2 cycles later for exactly 64 cycles; `o_ser_data` = 1 on the first UI only; `o_ser_done` on UI 64.
- Push 64'hA5A5_5A5A_F0F0_0F0F and 64'h1234_5678_9ABC_DEF0 on consecutive cycles, gap enabled → both serialized LSB-first with exactly 32 low/disabled cycles between them. With the macro undefined → 128 contiguous UIs.
- Push 5 words in 5 cycles with `DEPTH`=4 while the serializer is busy → `o_fifo_full` = 1; 5th word dropped with one `o_overflow` pulse; 4 words sent intact.
- With FIFO full, push on the cycle the serializer pops → push accepted; count stays 4; no overflow.
- Assert `i_rst` at UI 20 of a word with 2 more queued → outputs 0 immediately; `o_fifo_empty` = 1; after release no bits are emitted until a new push.
- Idle period: no pushes for 200 cycles → `o_busy` = 0; `o_ser_clk_en` = 0 throughout.

Source files
------------

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: FIFO-buffered 64-bit words shifted LSB-first; SB_TX_MIN_GAP_EN adds GAP_UI dead cycles between words.
// Latency: first bit two cycles after the push from idle.
// Backpressure: o_fifo_full to upstream; a push while full and not popping is dropped and flagged on o_overflow.
module sb_tx_serializer #(
  parameter int DEPTH  = 4,
  parameter int GAP_UI = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_write_enable,
  input  logic [63:0] i_tx_data,
  output logic        o_fifo_full,
  output logic        o_fifo_empty,
  output logic        o_overflow,
  output logic        o_ser_data,
  output logic        o_ser_clk_en,
  output logic        o_ser_done,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sb_tx_serializer: DEPTH must be a power of two >= 2");
  end
  if (GAP_UI < 1) begin : g_bad_gap
    $error("sb_tx_serializer: GAP_UI must be >= 1");
  end

`ifdef SB_TX_MIN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int GW = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;
  logic [GW-1:0] gap_cnt;
  logic          gap_done;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   shreg;
  logic [5:0]    bit_cnt;
  logic [63:0]   head;
  logic          last_bit;
  logic          pop;
  logic          push;

  assign head     = mem[rd_ptr];
  assign last_bit = (state == SHIFT) && (bit_cnt == 6'd63);

  // A pop only happens where a new word may start; never on an empty FIFO.
`ifdef SB_TX_MIN_GAP_EN
  assign gap_done = (state == GAP) && (gap_cnt == GW'(GAP_UI - 1));
  assign pop      = !o_fifo_empty && ((state == IDLE) || gap_done);
`else
  assign pop      = !o_fifo_empty && ((state == IDLE) || last_bit);
`endif

  assign push         = i_write_enable && ((count != CW'(DEPTH)) || pop);
  assign o_fifo_full  = (count == CW'(DEPTH));
  assign o_fifo_empty = (count == '0);
  assign o_busy       = (state != IDLE) || !o_fifo_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_write_enable && !push;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage is not reset; discarding contents is done by clearing pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      o_ser_data   <= 1'b0;
      o_ser_clk_en <= 1'b0;
      o_ser_done   <= 1'b0;
`ifdef SB_TX_MIN_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      o_ser_done <= 1'b0;
      if (pop) begin
        // Bit 0 goes straight to the output register; the rest waits in shreg.
        state        <= SHIFT;
        shreg        <= {1'b0, head[63:1]};
        bit_cnt      <= '0;
        o_ser_data   <= head[0];
        o_ser_clk_en <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (!last_bit) begin
              o_ser_data <= shreg[0];
              shreg      <= {1'b0, shreg[63:1]};
              bit_cnt    <= bit_cnt + 6'd1;
              o_ser_done <= (bit_cnt == 6'd62);
            end else begin
              o_ser_data   <= 1'b0;
              o_ser_clk_en <= 1'b0;
`ifdef SB_TX_MIN_GAP_EN
              state        <= GAP;
              gap_cnt      <= '0;
`else
              state        <= IDLE;
`endif
            end
          end
`ifdef SB_TX_MIN_GAP_EN
          GAP: begin
            gap_cnt <= gap_cnt + GW'(1);
            if (gap_done) begin
              state <= IDLE;
            end
          end
`endif
          default: begin
            o_ser_data   <= 1'b0;
            o_ser_clk_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
